// File: rtl/spi_burst_slave_pkg.sv
// Shared definitions for the SPI burst register slave: FSM encoding,
// command-byte layout and the value returned for unmapped reads.
package spi_burst_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  localparam int          CMD_WR_BIT = 7;
  localparam logic [7:0]  RD_INVALID = 8'hFF;

endpackage

// File: rtl/spi_burst_slave_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with a third flop
// holding the previous synchronised level for rise/fall detection.
module spi_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= IDLE_LVL;
      sync_p1 <= IDLE_LVL;
      prev_p2 <= IDLE_LVL;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign dout = sync_p1;
  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_burst_slave.sv
// SPI slave giving burst read/write access to a byte register image, with
// auto-incrementing address and prefetched read data.
module spi_burst_slave
  import spi_burst_slave_pkg::*;
#(
  parameter int RW_REG_COUNT = 23,
  parameter int RO_REG_COUNT = 1,
  parameter int CPOL         = 0,
  parameter int CPHA         = 0,
  parameter int AW           = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_cs_n,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  input  logic [RW_REG_COUNT*8-1:0] rw_data,
  input  logic [RO_REG_COUNT*8-1:0] ro_data,
  output logic [AW-1:0]             wr_addr,
  output logic [7:0]                wr_data,
  output logic                      wr_strobe,
  output logic                      busy
);

  localparam int            TOTAL     = RW_REG_COUNT + RO_REG_COUNT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [AW:0]   RW_END    = (AW+1)'(RW_REG_COUNT);
  localparam logic          SCLK_IDLE = (CPOL != 0);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.IDLE_LVL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_cs_n),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.IDLE_LVL(SCLK_IDLE)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_clk),
    .dout (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_mosi),
    .dout (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_edges = ^{cs_rise, sclk_s, mosi_rise, mosi_fall};

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [1:0]    settle_q, settle_d;

  logic [7:0]    rx_next;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_val;

  assign rx_next  = {rx_q[6:0], mosi_s};
  assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
  // At the end of the command byte the address is still in the shifter.
  assign rd_addr  = (state_q == ST_CMD) ? rx_next[AW-1:0] : addr_inc;

  always_comb begin
    rd_val = RD_INVALID;
    for (int i = 0; i < RW_REG_COUNT; i++) begin
      if (rd_addr == AW'(i)) rd_val = rw_data[i*8 +: 8];
    end
    for (int i = 0; i < RO_REG_COUNT; i++) begin
      if (rd_addr == AW'(RW_REG_COUNT + i)) rd_val = ro_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      settle_q    <= settle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // Synchronisers are preloaded idle after reset; an edge seen before they
    // have flushed is an artefact, not a real chip-select assertion.
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall && settle_q == 2'd3) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sample_edge) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = rx_next[AW-1:0];
              if (rx_next[CMD_WR_BIT]) begin
                state_d = ST_WR;
              end else begin
                state_d = ST_RD;
                tx_d    = rd_val;
              end
            end
          end
        end
        ST_WR: begin
          if (sample_edge) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ({1'b0, addr_q} < RW_END) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = rx_next;
              end
              addr_d = addr_inc;
            end
          end
        end
        ST_RD: begin
          if (shift_edge) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = addr_inc;
              tx_d   = rd_val;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign spi_miso  = miso_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_burst_slave.sv
// Directed bench for spi_burst_slave: one DUT per SPI mode sharing the bus,
// selected by its own chip select.
module tb_spi_burst_slave;

  localparam int RW   = 23;
  localparam int RO   = 1;
  localparam int AW   = 7;
  localparam int HALF = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            spi_clk;
  logic            spi_mosi;
  logic [3:0]      cs_v;
  logic [RW*8-1:0] rw_data;
  logic [RO*8-1:0] ro_data;
  logic [3:0]      miso_v;
  logic [3:0]      stb_v;
  logic [3:0]      busy_v;
  logic [AW-1:0]   waddr_v [4];
  logic [7:0]      wdata_v [4];

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_smp = 0;
  logic [1:0] cur_m = 2'd0;

  logic [AW-1:0] stb_a [$];
  logic [7:0]    stb_d [$];
  int            stb_c [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_burst_slave #(
      .RW_REG_COUNT(RW),
      .RO_REG_COUNT(RO),
      .CPOL        (g / 2),
      .CPHA        (g % 2),
      .AW          (AW)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_cs_n (cs_v[g]),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (miso_v[g]),
      .rw_data  (rw_data),
      .ro_data  (ro_data),
      .wr_addr  (waddr_v[g]),
      .wr_data  (wdata_v[g]),
      .wr_strobe(stb_v[g]),
      .busy     (busy_v[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stb_v[cur_m] === 1'b1) begin
      stb_a.push_back(waddr_v[cur_m]);
      stb_d.push_back(wdata_v[cur_m]);
      stb_c.push_back(cyc);
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    spi_clk  = cur_m[1];
    spi_mosi = 1'b0;
    ticks(4);
    stb_a.delete();
    stb_d.delete();
    stb_c.delete();
    cs_v = 4'hF;
    cs_v[cur_m] = 1'b0;
    ticks(6);
  endtask

  task automatic frame_end();
    ticks(HALF);
    cs_v = 4'hF;
    ticks(8);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cur_m[0]) begin
        spi_mosi = tx[i];
        ticks(HALF);
        rx[i] = miso_v[cur_m];
        spi_clk = ~cur_m[1];
        last_smp = cyc;
        ticks(HALF);
        spi_clk = cur_m[1];
      end else begin
        spi_clk  = ~cur_m[1];
        spi_mosi = tx[i];
        ticks(HALF);
        rx[i] = miso_v[cur_m];
        spi_clk = cur_m[1];
        last_smp = cyc;
        ticks(HALF);
      end
    end
  endtask

  task automatic test_reset();
    for (int m = 0; m < 4; m++) begin
      tests++;
      if ({busy_v[m], miso_v[m], stb_v[m]} !== 3'b000) begin
        fails++;
        $display("FAIL reset_ctrl[%0d]: busy/miso/strobe got %b expected 000", m,
                 {busy_v[m], miso_v[m], stb_v[m]});
      end
      tests++;
      if ({waddr_v[m], wdata_v[m]} !== '0) begin
        fails++;
        $display("FAIL reset_wr[%0d]: addr %h data %h expected 0 0", m, waddr_v[m], wdata_v[m]);
      end
    end
  endtask

  task automatic test_write_single(input logic [1:0] m);
    logic [7:0] rx;
    cur_m = m;
    frame_start();
    xfer(8'h85, 8, rx);
    tests++;
    if (busy_v[m] !== 1'b1) begin
      fails++;
      $display("FAIL wr_busy[m%0d]: got %b expected 1", m, busy_v[m]);
    end
    xfer(8'hA5, 8, rx);
    ticks(4);
    tests++;
    if (stb_a.size() != 1) begin
      fails++;
      $display("FAIL wr_count[m%0d]: got %0d strobes expected 1", m, stb_a.size());
    end else begin
      tests++;
      if (stb_a[0] !== 7'd5 || stb_d[0] !== 8'hA5) begin
        fails++;
        $display("FAIL wr_value[m%0d]: addr %h data %h expected 05 a5", m, stb_a[0], stb_d[0]);
      end
      tests++;
      if (stb_c[0] - last_smp != 3) begin
        fails++;
        $display("FAIL wr_latency[m%0d]: got %0d cycles expected 3", m, stb_c[0] - last_smp);
      end
    end
    frame_end();
    tests++;
    if (busy_v[m] !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle[m%0d]: busy got %b expected 0", m, busy_v[m]);
    end
  endtask

  task automatic test_burst_write();
    logic [7:0]    rx;
    logic [AW-1:0] ea [3];
    logic [7:0]    ed [3];
    ea = '{7'd21, 7'd22, 7'd0};
    ed = '{8'h11, 8'h22, 8'h44};
    cur_m = 2'd0;
    frame_start();
    xfer(8'h95, 8, rx);
    xfer(8'h11, 8, rx);
    xfer(8'h22, 8, rx);
    xfer(8'h33, 8, rx);
    xfer(8'h44, 8, rx);
    frame_end();
    tests++;
    if (stb_a.size() != 3) begin
      fails++;
      $display("FAIL burst_wr_count: got %0d strobes expected 3", stb_a.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (stb_a[k] !== ea[k] || stb_d[k] !== ed[k]) begin
          fails++;
          $display("FAIL burst_wr[%0d]: addr %h data %h expected %h %h", k,
                   stb_a[k], stb_d[k], ea[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_burst_read(input logic [1:0] m);
    logic [7:0] rx;
    logic [7:0] exp_b [3];
    exp_b = '{8'h3C, 8'hC3, 8'h01};
    cur_m = m;
    frame_start();
    xfer(8'h16, 8, rx);
    for (int k = 0; k < 3; k++) begin
      xfer(8'h00, 8, rx);
      tests++;
      if (rx !== exp_b[k]) begin
        fails++;
        $display("FAIL burst_rd[m%0d][%0d]: got %h expected %h", m, k, rx, exp_b[k]);
      end
    end
    frame_end();
    tests++;
    if (stb_a.size() != 0) begin
      fails++;
      $display("FAIL rd_no_strobe[m%0d]: got %0d strobes expected 0", m, stb_a.size());
    end
  endtask

  task automatic test_read_invalid();
    logic [7:0] rx;
    cur_m = 2'd0;
    frame_start();
    xfer(8'h7F, 8, rx);
    xfer(8'h00, 8, rx);
    frame_end();
    tests++;
    if (rx !== 8'hFF) begin
      fails++;
      $display("FAIL rd_invalid: got %h expected ff", rx);
    end
  endtask

  task automatic test_partial_write();
    logic [7:0] rx;
    cur_m = 2'd0;
    frame_start();
    xfer(8'h83, 8, rx);
    xfer(8'hF0, 4, rx);
    frame_end();
    tests++;
    if (stb_a.size() != 0) begin
      fails++;
      $display("FAIL partial_wr: got %0d strobes expected 0", stb_a.size());
    end
    frame_start();
    xfer(8'h87, 8, rx);
    xfer(8'h5A, 8, rx);
    frame_end();
    tests++;
    if (stb_a.size() != 1) begin
      fails++;
      $display("FAIL after_partial_count: got %0d strobes expected 1", stb_a.size());
    end else begin
      tests++;
      if (stb_a[0] !== 7'd7 || stb_d[0] !== 8'h5A) begin
        fails++;
        $display("FAIL after_partial: addr %h data %h expected 07 5a", stb_a[0], stb_d[0]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    cur_m = 2'd0;
    frame_start();
    xfer(8'h17, 8, rx);
    xfer(8'h00, 1, rx);
    tests++;
    if (miso_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_rd_active: miso %b busy %b expected 1 1", miso_v[0], busy_v[0]);
    end
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    tests++;
    if (miso_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_rd_reset: miso %b busy %b expected 0 0", miso_v[0], busy_v[0]);
    end
    ticks(10);
    tests++;
    if (busy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL no_fresh_edge: busy got %b expected 0", busy_v[0]);
    end
    frame_end();
  endtask

  initial begin
    rst_n    = 1'b0;
    cs_v     = 4'hF;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < RW; i++) rw_data[i*8 +: 8] = 8'(3 * i + 1);
    rw_data[22*8 +: 8] = 8'h3C;
    ro_data = 8'hC3;
    ticks(3);
    rst_n = 1'b1;
    ticks(1);
    test_reset();
    ticks(5);
    test_write_single(2'd0);
    test_burst_write();
    test_burst_read(2'd0);
    test_read_invalid();
    test_partial_write();
    for (int m = 1; m < 4; m++) begin
      test_write_single(2'(m));
      test_burst_read(2'(m));
    end
    test_reset_mid_read();
    test_write_single(2'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_burst_slave.md
SPI_BURST_SLAVE -- requirements
Module: spi_burst_slave

Interface
REQ-001 Parameter RW_REG_COUNT, default 23: number of read-write byte registers, addresses 0..RW_REG_COUNT-1.
REQ-002 Parameter RO_REG_COUNT, default 1: number of read-only byte registers, addresses RW_REG_COUNT..RW_REG_COUNT+RO_REG_COUNT-1.
REQ-003 Parameter CPOL, default 0: SPI clock idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Parameter AW, default 7: address width; RW_REG_COUNT+RO_REG_COUNT SHALL be <= 2**AW and AW SHALL be <= 7.
REQ-006 clk  in  1  system clock; reset rst_n, synchronous, active-low; clock clk.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 spi_cs_n, spi_clk, spi_mosi  in  1 each  asynchronous SPI pins.
REQ-009 spi_miso  out  1  serial read data, MSB first.
REQ-010 rw_data  in  RW_REG_COUNT*8  flattened RW register image, byte i at bits [8i+7:8i].
REQ-011 ro_data  in  RO_REG_COUNT*8  flattened RO register image, same packing.
REQ-012 wr_addr  out  AW  write address; wr_data  out  8  write byte; wr_strobe  out  1  one-clk write pulse.
REQ-013 busy  out  1  high while a frame is active (state not IDLE).

Function
REQ-014 spi_cs_n, spi_clk and spi_mosi SHALL pass through 2-flop synchronisers; all edge detection uses synchronised values; clk SHALL be >= 6x spi_clk.
REQ-015 Sample edge = leading edge when CPHA=0, trailing edge when CPHA=1; shift edge = the other edge; leading = rising when CPOL=0, falling when CPOL=1.
REQ-016 FSM states IDLE, CMD, WR, RD; IDLE->CMD on synchronised cs_n falling; any state -> IDLE on synchronised cs_n high, within the same clk.
REQ-017 CMD: 8 bits shifted in MSB first on sample edges; bit7 = 1 write, 0 read; bits[AW-1:0] = start address; unused bits ignored.
REQ-018 At the 8th CMD sample edge: latch address; go to WR if write, else RD and load tx byte from address.
REQ-019 Read value: rw_data byte if addr < RW_REG_COUNT; ro_data byte if in RO range; 8'hFF otherwise.
REQ-020 RD: on each shift edge, spi_miso <= tx[7] and tx shifts left; at every 8th sample edge, address increments and tx reloads from the new address (prefetch), so bursts stream without gaps.
REQ-021 WR: bits shifted in on sample edges; at every 8th sample edge wr_strobe pulses one clk with the assembled byte and current address, then address increments.
REQ-022 wr_strobe SHALL be suppressed for addresses >= RW_REG_COUNT; address still increments.
REQ-023 Address wrap: after RW_REG_COUNT+RO_REG_COUNT-1, the next address is 0.
REQ-024 wr_strobe latency: asserted exactly 3 clk cycles after the raw spi_clk sample edge, i.e. 2 synchroniser cycles + 1 registered cycle.
REQ-025 Partial byte at cs_n deassert: discarded, no wr_strobe; bit counter cleared.
REQ-026 spi_miso holds its last value outside RD; 0 after reset.
REQ-027 rw_data/ro_data are sampled only at load instants; later changes do not affect the byte in flight.

Reset
REQ-028 On rst_n low: state IDLE, bit counter 0, address 0, shift/tx registers 0, spi_miso 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0; synchronisers loaded with idle levels (cs_n 1, spi_clk CPOL).
REQ-029 Reset mid-frame aborts the frame; the next frame requires a fresh cs_n falling edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the command bit position (CMD_WR_BIT = 7) and the invalid read value (8'hFF).
REQ-031 One sub-module spi_sync_edge (2-flop synchroniser plus rise/fall detect) SHALL be instantiated per input pin.

Verification
REQ-032 Mode 0: cmd 8'h85 then 8'hA5 -> one wr_strobe, wr_addr=5, wr_data=8'hA5.
REQ-033 Burst write: cmd 8'h95 (addr 21), data 11, 22, 33, 44 -> strobes at 21 (11) and 22 (22); addr 23 (RO) suppressed; wrap to 0 (44).
REQ-034 Burst read with rw_data byte 22 = 8'h3C and ro_data = 8'hC3: cmd 8'h16 then 3 bytes -> MISO returns 3C, C3, then rw byte 0.
REQ-035 Read of addr 8'h7F -> 8'hFF.
REQ-036 cs_n raised after 4 data bits of a write -> no wr_strobe; next frame decodes correctly.
REQ-037 Repeat REQ-032 and REQ-034 for CPOL/CPHA = 01, 10, 11 -> identical results; rst_n pulsed mid-read -> spi_miso 0, busy 0.
